// File: rtl/sha256_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_feeder
// Brief    : Byte-stream to SHA-256 block feeder with FIPS 180-4 padding and
//            chaining-value feedback; optional macro SHA256_FEEDER_DIGEST_HOLD_EN
//            holds the digest until digest_ready.
// Revision : 1.0
// ============================================================================
module sha256_msg_feeder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_keep,
  output logic         in_ready,
  output logic [511:0] blk_M,
  output logic [255:0] blk_H,
  output logic         blk_valid,
  input  logic [255:0] core_H,
  input  logic         core_valid,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
);

  localparam logic [255:0] c_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_FILL  = 3'd1;
  localparam logic [2:0] c_S_PAD   = 3'd2;
  localparam logic [2:0] c_S_ISSUE = 3'd3;
  localparam logic [2:0] c_S_WAIT  = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;

  logic [2:0]       state_q,  state_d;
  logic [511:0]     buf_q,    buf_d;
  logic [255:0]     h_q,      h_d;
  logic [255:0]     digest_q, digest_d;
  logic [6:0]       pos_q,    pos_d;
  logic [LEN_W-1:0] cnt_q,    cnt_d;
  logic             final_q,  final_d;
  logic             pend_q,   pend_d;
  logic             pend80_q, pend80_d;

  logic [63:0]      w_len;
  logic [5:0]       w_bidx;
  logic             w_addbyte;

  assign w_len     = {{(61-LEN_W){1'b0}}, cnt_q, 3'b000};
  // Byte 0 lives in the most significant byte of the block.
  assign w_bidx    = 6'd63 - pos_q[5:0];
  assign w_addbyte = in_keep | ~in_last;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    h_d      = h_q;
    digest_d = digest_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    final_d  = final_q;
    pend_d   = pend_q;
    pend80_d = pend80_q;
    case (state_q)
      c_S_IDLE: begin
        buf_d    = '0;
        h_d      = c_IV;
        cnt_d    = '0;
        pos_d    = '0;
        final_d  = 1'b0;
        pend_d   = 1'b0;
        pend80_d = 1'b0;
        state_d  = c_S_FILL;
      end
      c_S_FILL: begin
        if (in_valid) begin
          if (w_addbyte) begin
            buf_d[{w_bidx, 3'b000} +: 8] = in_data;
            pos_d = pos_q + 7'd1;
            cnt_d = cnt_q + LEN_W'(1);
          end
          if (in_last) begin
            state_d = c_S_PAD;
          end else if (pos_q == 7'd63) begin
            final_d = 1'b0;
            state_d = c_S_ISSUE;
          end
        end
      end
      c_S_PAD: begin
        // A pending padding-only block is built from scratch; otherwise the
        // terminator goes right after the last message byte.
        if (pend_q) begin
          buf_d = '0;
          if (pend80_q) begin
            buf_d[511:504] = 8'h80;
          end
          buf_d[63:0] = w_len;
          final_d     = 1'b1;
          pend_d      = 1'b0;
        end else if (pos_q[6]) begin
          final_d  = 1'b0;
          pend_d   = 1'b1;
          pend80_d = 1'b1;
        end else begin
          buf_d[{w_bidx, 3'b000} +: 8] = 8'h80;
          if (pos_q <= 7'd55) begin
            buf_d[63:0] = w_len;
            final_d     = 1'b1;
          end else begin
            final_d  = 1'b0;
            pend_d   = 1'b1;
            pend80_d = 1'b0;
          end
        end
        state_d = c_S_ISSUE;
      end
      c_S_ISSUE: begin
        state_d = c_S_WAIT;
      end
      c_S_WAIT: begin
        if (core_valid) begin
          h_d = core_H;
          if (final_q) begin
            digest_d = core_H;
            state_d  = c_S_DONE;
          end else if (pend_q) begin
            state_d = c_S_PAD;
          end else begin
            buf_d   = '0;
            pos_d   = '0;
            state_d = c_S_FILL;
          end
        end
      end
      c_S_DONE: begin
`ifdef SHA256_FEEDER_DIGEST_HOLD_EN
        if (digest_ready) begin
          state_d = c_S_IDLE;
        end
`else
        state_d = c_S_IDLE;
`endif
      end
      default: begin
        state_d = c_S_IDLE;
      end
    endcase
  end

`ifndef SHA256_FEEDER_DIGEST_HOLD_EN
  logic w_unused_ready;
  assign w_unused_ready = digest_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_S_IDLE;
      buf_q    <= '0;
      h_q      <= c_IV;
      digest_q <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      final_q  <= 1'b0;
      pend_q   <= 1'b0;
      pend80_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      final_q  <= final_d;
      pend_q   <= pend_d;
      pend80_q <= pend80_d;
    end
  end

  assign in_ready     = (state_q == c_S_FILL);
  assign blk_valid    = (state_q == c_S_ISSUE);
  assign digest_valid = (state_q == c_S_DONE);
  assign blk_M        = buf_q;
  assign blk_H        = h_q;
  assign digest       = digest_q;

endmodule
`default_nettype wire
